pulse_sync_hs: RTL and testbench

- Multi-channel pulse synchronizer from the src_clk domain to the des_clk domain; works with any clock ratio.
- Each channel sends one request per pulse as a req toggle and waits for an ack toggle returned from the destination.
- Pulses that arrive while a channel is busy are queued in a per-channel saturating counter and replayed, so none are lost until the counter is full.
- Used wherever event pulses (interrupts, counter ticks, triggers) cross between unrelated clocks and every event must arrive.

---
 rtl/pulse_sync_hs.sv | 134 +++++++++++++
 tb/tb_pulse_sync_hs.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_sync_hs.sv
// Multi-channel pulse synchronizer, src_clk -> des_clk, using a req/ack toggle handshake.
// Pulses arriving while a channel is busy are queued in a saturating counter and replayed;
// events beyond the counter capacity are dropped and flagged in a sticky overflow bit.
module pulse_sync_hs #(
  parameter int unsigned CH          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                src_clk,
  input  logic                src_rstn,
  input  logic                des_clk,
  input  logic                des_rstn,
  input  logic [CH-1:0]       src_pulse,
  input  logic                src_ovf_clr,
  output logic [CH-1:0]       src_busy,
  output logic [CH-1:0]       src_ovf,
  output logic [CH*CNT_W-1:0] src_pend,
  output logic [CH-1:0]       des_pulse
);

  localparam logic [CNT_W-1:0] PendMax = '1;
  localparam logic [CNT_W-1:0] PendOne = CNT_W'(1);

  // Source domain state
  logic [CH-1:0]    req_tgl_d, req_tgl_q;
  logic [CH-1:0]    ack_sync_d [SYNC_STAGES];
  logic [CH-1:0]    ack_sync_q [SYNC_STAGES];
  logic [CNT_W-1:0] pend_d [CH];
  logic [CNT_W-1:0] pend_q [CH];
  logic [CH-1:0]    ovf_set;
  logic [CH-1:0]    ovf_d, ovf_q;
  logic [CH-1:0]    ack_s;
  logic [CH-1:0]    src_idle;

  // Destination domain state
  logic [CH-1:0]    req_sync_d [SYNC_STAGES];
  logic [CH-1:0]    req_sync_q [SYNC_STAGES];
  logic [CH-1:0]    ack_tgl_d, ack_tgl_q;
  logic [CH-1:0]    des_pulse_d, des_pulse_q;
  logic [CH-1:0]    req_s;

  assign ack_s    = ack_sync_q[SYNC_STAGES-1];
  assign src_idle = ~(req_tgl_q ^ ack_s);
  assign src_busy = ~src_idle;
  assign src_ovf  = ovf_q;

  for (genvar g = 0; g < CH; g++) begin : g_pend_out
    assign src_pend[g*CNT_W +: CNT_W] = pend_q[g];
  end

  // Ack toggle shift chain into the source domain; stage 0 samples the raw des-domain flop.
  always_comb begin
    ack_sync_d[0] = ack_tgl_q;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      ack_sync_d[s] = ack_sync_q[s-1];
    end
  end

  // Per-channel send/queue/drop decision.
  always_comb begin
    req_tgl_d = req_tgl_q;
    ovf_set   = '0;
    for (int i = 0; i < CH; i++) begin
      pend_d[i] = pend_q[i];
    end
    for (int i = 0; i < CH; i++) begin
      if (src_idle[i]) begin
        // A new pulse and a queued one sent together leave the count unchanged.
        if (src_pulse[i] || (pend_q[i] != '0)) begin
          req_tgl_d[i] = ~req_tgl_q[i];
        end
        if (!src_pulse[i] && (pend_q[i] != '0)) begin
          pend_d[i] = pend_q[i] - PendOne;
        end
      end else if (src_pulse[i]) begin
        if (pend_q[i] != PendMax) begin
          pend_d[i] = pend_q[i] + PendOne;
        end else begin
          ovf_set[i] = 1'b1;
        end
      end
    end
    // A set in the same cycle beats the clear.
    ovf_d = (ovf_q & ~{CH{src_ovf_clr}}) | ovf_set;
  end

  // Source domain registers.
  always_ff @(posedge src_clk or negedge src_rstn) begin
    if (!src_rstn) begin
      req_tgl_q <= '0;
      ovf_q     <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        ack_sync_q[s] <= '0;
      end
      for (int i = 0; i < CH; i++) begin
        pend_q[i] <= '0;
      end
    end else begin
      req_tgl_q  <= req_tgl_d;
      ovf_q      <= ovf_d;
      ack_sync_q <= ack_sync_d;
      pend_q     <= pend_d;
    end
  end

  // Req toggle shift chain into the destination domain, ack echo and pulse regeneration.
  always_comb begin
    req_sync_d[0] = req_tgl_q;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      req_sync_d[s] = req_sync_q[s-1];
    end
    req_s       = req_sync_q[SYNC_STAGES-1];
    ack_tgl_d   = req_s;
    des_pulse_d = req_s ^ ack_tgl_q;
  end

  // Destination domain registers.
  always_ff @(posedge des_clk or negedge des_rstn) begin
    if (!des_rstn) begin
      ack_tgl_q   <= '0;
      des_pulse_q <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        req_sync_q[s] <= '0;
      end
    end else begin
      ack_tgl_q   <= ack_tgl_d;
      des_pulse_q <= des_pulse_d;
      req_sync_q  <= req_sync_d;
    end
  end

  assign des_pulse = des_pulse_q;

endmodule

// File: tb/tb_pulse_sync_hs.sv
// Directed bench for pulse_sync_hs: single event, burst, overflow, collisions, reset, ratios.
`timescale 1ns / 1ps
module tb_pulse_sync_hs;

  localparam int CH  = 4;
  localparam int SS  = 2;
  localparam int CW  = 4;

  logic             src_clk, des_clk;
  logic             src_rstn, des_rstn;
  logic [CH-1:0]    src_pulse;
  logic             src_ovf_clr;
  logic [CH-1:0]    src_busy, src_ovf, des_pulse;
  logic [CH*CW-1:0] src_pend;

  realtime src_half = 5.0;   // 100 MHz
  realtime des_half = 18.5;  // ~27 MHz

  int n_chk  = 0;
  int n_fail = 0;

  int hi_cnt   [CH];
  int rise_cnt [CH];
  int hi_base  [CH];
  int rise_base[CH];
  logic [CH-1:0] prev_pulse = '0;

  pulse_sync_hs #(
    .CH          (CH),
    .SYNC_STAGES (SS),
    .CNT_W       (CW)
  ) u_dut (
    .src_clk     (src_clk),
    .src_rstn    (src_rstn),
    .des_clk     (des_clk),
    .des_rstn    (des_rstn),
    .src_pulse   (src_pulse),
    .src_ovf_clr (src_ovf_clr),
    .src_busy    (src_busy),
    .src_ovf     (src_ovf),
    .src_pend    (src_pend),
    .des_pulse   (des_pulse)
  );

  initial begin
    src_clk = 1'b0;
    forever #(src_half) src_clk = ~src_clk;
  end

  initial begin
    des_clk = 1'b0;
    forever #(des_half) des_clk = ~des_clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Count delivered high cycles and rising edges per channel.
  initial begin
    for (int c = 0; c < CH; c++) begin
      hi_cnt[c]   = 0;
      rise_cnt[c] = 0;
    end
    forever begin
      @(negedge des_clk);
      for (int c = 0; c < CH; c++) begin
        if (des_pulse[c] === 1'b1) hi_cnt[c]++;
        if (des_pulse[c] === 1'b1 && prev_pulse[c] !== 1'b1) rise_cnt[c]++;
      end
      prev_pulse = des_pulse;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] pend_of(input int ch);
    return src_pend[ch*CW +: CW];
  endfunction

  task automatic snap();
    for (int c = 0; c < CH; c++) begin
      hi_base[c]   = hi_cnt[c];
      rise_base[c] = rise_cnt[c];
    end
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((src_busy !== '0 || src_pend !== '0) && k < 20000) begin
      @(posedge src_clk);
      #1;
      k++;
    end
    chk({tag, "_drained"}, (src_busy === '0 && src_pend === '0), 1);
    repeat (3) @(negedge des_clk);
  endtask

  task automatic single_event(input bit chk_lat);
    int lat;
    bit got;
    snap();
    @(posedge src_clk);
    #1 src_pulse = 4'b0001;
    lat = 0;
    got = 0;
    fork
      begin
        @(posedge src_clk);
        #1 src_pulse = '0;
        chk("single_busy", src_busy, 4'b0001);
      end
      begin
        @(posedge src_clk);
        for (int k = 0; k < 12 && !got; k++) begin
          @(posedge des_clk);
          lat++;
          #0.5;
          if (des_pulse[0] === 1'b1) got = 1;
        end
      end
    join
    if (chk_lat) chk("single_lat_3_to_4", (got && (lat == 3 || lat == 4)), 1);
    drain("single");
    chk("single_ch0_cnt", hi_cnt[0] - hi_base[0], 1);
    chk("single_other_cnt", (hi_cnt[1] - hi_base[1]) + (hi_cnt[2] - hi_base[2])
        + (hi_cnt[3] - hi_base[3]), 0);
    chk("single_busy_done", src_busy, 4'b0000);
  endtask

  // n back-to-back pulses on one channel; returns the highest pend seen.
  task automatic drive_burst(input int ch, input int n, input int clr_at, output int pk);
    pk = 0;
    for (int k = 0; k < n; k++) begin
      src_pulse      = '0;
      src_pulse[ch]  = 1'b1;
      src_ovf_clr    = (k == clr_at);
      @(posedge src_clk);
      #1;
      if (int'(pend_of(ch)) > pk) pk = int'(pend_of(ch));
    end
    src_pulse   = '0;
    src_ovf_clr = 1'b0;
  endtask

  task automatic burst10(input bit chk_pk);
    int pk;
    snap();
    drive_burst(1, 10, -1, pk);
    if (chk_pk) chk("burst_pend_peak", pk, 9);
    drain("burst");
    chk("burst_ch1_cnt", hi_cnt[1] - hi_base[1], 10);
    chk("burst_ch1_separate", rise_cnt[1] - rise_base[1], 10);
    chk("burst_ovf", src_ovf, 4'b0000);
    chk("burst_pend_end", pend_of(1), 0);
  endtask

  initial begin
    int pk;
    src_rstn    = 1'b0;
    des_rstn    = 1'b0;
    src_pulse   = '0;
    src_ovf_clr = 1'b0;

    repeat (3) @(posedge src_clk);
    #1;
    chk("reset_busy", src_busy, 0);
    chk("reset_ovf", src_ovf, 0);
    chk("reset_pend", src_pend, 0);
    chk("reset_des_pulse", des_pulse, 0);
    @(negedge src_clk);
    src_rstn = 1'b1;
    des_rstn = 1'b1;
    repeat (3) @(posedge src_clk);

    single_event(1'b1);
    burst10(1'b1);

    // Overflow with a slow destination so the whole burst sees a busy channel.
    des_half = 100.0;
    repeat (2) @(posedge des_clk);
    snap();
    drive_burst(1, 20, 19, pk);
    chk("ovf_pend_peak", pk, 15);
    chk("ovf_pend_sat", pend_of(1), 15);
    chk("ovf_set_beats_clr", src_ovf, 4'b0010);
    src_ovf_clr = 1'b1;
    @(posedge src_clk);
    #1 src_ovf_clr = 1'b0;
    chk("ovf_cleared", src_ovf, 4'b0000);
    drain("ovf");
    chk("ovf_delivered", hi_cnt[1] - hi_base[1], 16);
    chk("ovf_separate", rise_cnt[1] - rise_base[1], 16);
    des_half = 18.5;
    repeat (2) @(posedge des_clk);

    // All channels in the same cycle.
    snap();
    @(posedge src_clk);
    #1 src_pulse = 4'b1111;
    @(posedge src_clk);
    #1 src_pulse = '0;
    drain("simul");
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("simul_ch%0d_cnt", c), hi_cnt[c] - hi_base[c], 1);
    end

    // New pulse on the exact cycle a queued pulse is sent.
    snap();
    drive_burst(2, 4, -1, pk);
    chk("replay_pend_pre", pend_of(2), 3);
    for (int k = 0; k < 400 && src_busy[2] !== 1'b0; k++) begin
      @(posedge src_clk);
      #1;
    end
    chk("replay_idle_seen", src_busy[2], 0);
    src_pulse = 4'b0100;
    @(posedge src_clk);
    #1 src_pulse = '0;
    chk("replay_pend_held", pend_of(2), 3);
    chk("replay_busy", src_busy[2], 1);
    drain("replay");
    chk("replay_delivered", hi_cnt[2] - hi_base[2], 5);

    // Reset both domains with transfers in flight.
    @(posedge src_clk);
    #1 src_pulse = 4'b1001;
    @(posedge src_clk);
    #1 src_pulse = 4'b1000;
    @(posedge src_clk);
    #1 src_pulse = '0;
    @(posedge src_clk);
    #1;
    src_rstn = 1'b0;
    des_rstn = 1'b0;
    #1;
    chk("midrst_busy", src_busy, 0);
    chk("midrst_ovf", src_ovf, 0);
    chk("midrst_pend", src_pend, 0);
    chk("midrst_des_pulse", des_pulse, 0);
    src_half = 20.0;  // 25 MHz
    des_half = 2.5;   // 200 MHz
    repeat (5) @(posedge src_clk);
    snap();
    @(negedge src_clk);
    src_rstn = 1'b1;
    des_rstn = 1'b1;
    repeat (50) @(posedge src_clk);
    #1;
    chk("postrst_no_pulse", (hi_cnt[0] - hi_base[0]) + (hi_cnt[3] - hi_base[3]), 0);
    chk("postrst_busy", src_busy, 0);

    // Fast destination, slow source.
    single_event(1'b0);
    burst10(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
